// File: rtl/pipe_pkg.sv
// pipe_pkg: types and constants shared by the pipeline tag bookkeeping.
//   stage_tag_t : hazard-relevant tag carried per pipeline register
//   TAG_BUBBLE  : all-zero tag loaded when a stage is killed
//   pipe_mode_e : per-cycle update mode (RUN / STALL / FLUSH)
package pipe_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_STALL = 2'd1,
    MODE_FLUSH = 2'd2
  } pipe_mode_e;

  // Stall wins over flush; the hazard unit re-issues flush once the stall clears.
  function automatic pipe_mode_e decode_mode(input logic stall, input logic flush);
    if (stall)      return MODE_STALL;
    else if (flush) return MODE_FLUSH;
    else            return MODE_RUN;
  endfunction

endpackage

// File: rtl/pipe_tag_reg.sv
// pipe_tag_reg: one pipeline tag register.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset (clears to a bubble)
//   en_i   : load tag_i when set, otherwise hold
//   kill_i : load a bubble (overrides en_i)
//   tag_i  : incoming tag
//   tag_o  : registered tag
module pipe_tag_reg
  import pipe_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       kill_i,
  input  stage_tag_t tag_i,
  output stage_tag_t tag_o
);

  stage_tag_t tag_q, tag_d;

  always_comb begin
    tag_d = tag_q;
    if (kill_i)    tag_d = TAG_BUBBLE;
    else if (en_i) tag_d = tag_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tag_q <= TAG_BUBBLE;
    else       tag_q <= tag_d;
  end

  assign tag_o = tag_q;

endmodule

// File: rtl/pipe_tag_ctrl.sv
// pipe_tag_ctrl: carries hazard tags through IF/ID, ID/EX, EX/MEM, MEM/WB,
// applies stall/flush and keeps retire/stall/flush counters.
//   clk, rst                 : clock, async active-high reset
//   if_valid                 : fetch presents a real instruction
//   id_rs1/rs2/rd, id_regwrite, id_memread : decoded fields of the IF/ID instruction
//   stall, flush             : hazard unit requests
//   pc_en, idex_en           : datapath register enables (= !stall)
//   ifid_valid, idex_*, exmem_*, memwb_* : exported stage tags
//   retire_cnt, stall_cnt, flush_cnt     : wrapping performance counters
module pipe_tag_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             stall,
  input  logic             flush,
  output logic             pc_en,
  output logic             idex_en,
  output logic             ifid_valid,
  output logic             idex_valid,
  output logic [4:0]       idex_rs1,
  output logic [4:0]       idex_rs2,
  output logic [4:0]       idex_rd,
  output logic             idex_regwrite,
  output logic             exmem_valid,
  output logic [4:0]       exmem_rd,
  output logic             exmem_regwrite,
  output logic             exmem_memread,
  output logic             memwb_valid,
  output logic [4:0]       memwb_rd,
  output logic             memwb_regwrite,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_mode_e mode;
  logic       in_stall, in_flush;
  stage_tag_t ifid_d, ifid_q, idex_d, idex_q, exmem_q, memwb_q;

  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

  assign mode     = decode_mode(stall, flush);
  assign in_stall = (mode == MODE_STALL);
  assign in_flush = (mode == MODE_FLUSH);

  assign pc_en   = !stall;
  assign idex_en = !stall;

  // IF/ID keeps only valid; the decoded fields arrive on id_* while the
  // instruction sits in IF/ID and are captured (gated by valid) into ID/EX.
  always_comb begin
    ifid_d       = TAG_BUBBLE;
    ifid_d.valid = if_valid;
    idex_d       = TAG_BUBBLE;
    if (ifid_q.valid) begin
      idex_d.valid    = 1'b1;
      idex_d.rs1      = id_rs1;
      idex_d.rs2      = id_rs2;
      idex_d.rd       = id_rd;
      idex_d.regwrite = id_regwrite;
      idex_d.memread  = id_memread;
    end
  end

  pipe_tag_reg u_ifid (
    .clk_i (clk), .rst_i (rst), .en_i (!in_stall), .kill_i (in_flush),
    .tag_i (ifid_d), .tag_o (ifid_q)
  );

  pipe_tag_reg u_idex (
    .clk_i (clk), .rst_i (rst), .en_i (!in_stall), .kill_i (in_flush),
    .tag_i (idex_d), .tag_o (idex_q)
  );

  // The branch in ID/EX survives a flush; only the younger stages die.
  pipe_tag_reg u_exmem (
    .clk_i (clk), .rst_i (rst), .en_i (1'b1), .kill_i (in_stall),
    .tag_i (idex_q), .tag_o (exmem_q)
  );

  pipe_tag_reg u_memwb (
    .clk_i (clk), .rst_i (rst), .en_i (1'b1), .kill_i (1'b0),
    .tag_i (exmem_q), .tag_o (memwb_q)
  );

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (memwb_q.valid) retire_cnt_d = retire_cnt_q + CNT_W'(1);
    if (in_stall)      stall_cnt_d  = stall_cnt_q  + CNT_W'(1);
    if (in_flush)      flush_cnt_d  = flush_cnt_q  + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ifid_valid     = ifid_q.valid;
  assign idex_valid     = idex_q.valid;
  assign idex_rs1       = idex_q.rs1;
  assign idex_rs2       = idex_q.rs2;
  assign idex_rd        = idex_q.rd;
  assign idex_regwrite  = idex_q.regwrite;
  assign exmem_valid    = exmem_q.valid;
  assign exmem_rd       = exmem_q.rd;
  assign exmem_regwrite = exmem_q.regwrite;
  assign exmem_memread  = exmem_q.memread;
  assign memwb_valid    = memwb_q.valid;
  assign memwb_rd       = memwb_q.rd;
  assign memwb_regwrite = memwb_q.regwrite;
  assign retire_cnt     = retire_cnt_q;
  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;

  // Tag fields that no consumer reads downstream of their stage.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{ifid_q.rs1, ifid_q.rs2, ifid_q.rd, ifid_q.regwrite,
                             ifid_q.memread, exmem_q.rs1, exmem_q.rs2,
                             memwb_q.rs1, memwb_q.rs2, memwb_q.memread};

endmodule

// File: tb/tb_pipe_tag_ctrl.sv
module tb_pipe_tag_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic if_valid, id_regwrite, id_memread, stall, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic pc_en, idex_en, ifid_valid, idex_valid, idex_regwrite;
  logic [4:0] idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic exmem_valid, exmem_regwrite, exmem_memread, memwb_valid, memwb_regwrite;
  logic [31:0] retire_cnt, stall_cnt, flush_cnt;

  logic w_pc_en, w_idex_en, w_ifid_valid, w_idex_valid, w_idex_regwrite;
  logic [4:0] w_idex_rs1, w_idex_rs2, w_idex_rd, w_exmem_rd, w_memwb_rd;
  logic w_exmem_valid, w_exmem_regwrite, w_exmem_memread, w_memwb_valid, w_memwb_regwrite;
  logic [3:0] w_retire_cnt, w_stall_cnt, w_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_tag_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .stall(stall), .flush(flush), .pc_en(pc_en), .idex_en(idex_en),
    .ifid_valid(ifid_valid), .idex_valid(idex_valid), .idex_rs1(idex_rs1),
    .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_regwrite(idex_regwrite),
    .exmem_valid(exmem_valid), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .exmem_memread(exmem_memread), .memwb_valid(memwb_valid), .memwb_rd(memwb_rd),
    .memwb_regwrite(memwb_regwrite), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  pipe_tag_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .stall(stall), .flush(flush), .pc_en(w_pc_en), .idex_en(w_idex_en),
    .ifid_valid(w_ifid_valid), .idex_valid(w_idex_valid), .idex_rs1(w_idex_rs1),
    .idex_rs2(w_idex_rs2), .idex_rd(w_idex_rd), .idex_regwrite(w_idex_regwrite),
    .exmem_valid(w_exmem_valid), .exmem_rd(w_exmem_rd), .exmem_regwrite(w_exmem_regwrite),
    .exmem_memread(w_exmem_memread), .memwb_valid(w_memwb_valid), .memwb_rd(w_memwb_rd),
    .memwb_regwrite(w_memwb_regwrite), .retire_cnt(w_retire_cnt), .stall_cnt(w_stall_cnt),
    .flush_cnt(w_flush_cnt)
  );

  // Reference model: pipe[0]=IF/ID (valid only), pipe[1..3]=ID/EX, EX/MEM, MEM/WB.
  typedef struct packed {
    bit       v;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } mtag_t;

  mtag_t       pipe [4];
  int unsigned m_retire, m_stall, m_flush;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    m_retire = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic drive_idle();
    if_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_regwrite = 0; id_memread = 0; stall = 0; flush = 0;
  endtask

  // One rising edge: DUT and model advance together; returns 1 time unit later.
  task automatic tick();
    mtag_t decoded;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (pipe[3].v) m_retire++;
      if (stall) begin
        m_stall++;
        pipe[3] = pipe[2];
        pipe[2] = '0;
      end else begin
        decoded = '0;
        if (pipe[0].v) decoded = '{v:1'b1, rs1:id_rs1, rs2:id_rs2, rd:id_rd,
                                   rw:id_regwrite, mr:id_memread};
        pipe[3] = pipe[2];
        pipe[2] = pipe[1];
        pipe[1] = decoded;
        pipe[0] = '0;
        pipe[0].v = if_valid;
        if (flush) begin
          m_flush++;
          pipe[1] = '0;
          pipe[0] = '0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    #2 rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({ifid_valid, idex_valid, exmem_valid, memwb_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_valids: got %b expected 0000",
                         {ifid_valid, idex_valid, exmem_valid, memwb_valid});
    end
    n_checks++;
    if ({retire_cnt, stall_cnt, flush_cnt} !== 96'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
                         retire_cnt, stall_cnt, flush_cnt);
    end
    // three valid instructions in flight plus a nonzero stall counter
    if_valid = 1; tick();
    stall = 1; tick();
    stall = 0; id_rd = 5'd1; id_regwrite = 1; tick();
    id_rd = 5'd2; tick();
    id_rd = 5'd3; tick();
    #2 rst = 1'b1; stall = 1'b1;
    #1;
    n_checks++;
    if ({ifid_valid, idex_valid, exmem_valid, memwb_valid, idex_regwrite, exmem_regwrite,
         memwb_regwrite, exmem_memread, idex_rd, exmem_rd, memwb_rd, idex_rs1, idex_rs2} !== 33'd0) begin
      n_fail++; $display("FAIL reset_async_tags: got %0h expected 0",
        {ifid_valid, idex_valid, exmem_valid, memwb_valid, idex_regwrite, exmem_regwrite,
         memwb_regwrite, exmem_memread, idex_rd, exmem_rd, memwb_rd, idex_rs1, idex_rs2});
    end
    n_checks++;
    if ({retire_cnt, stall_cnt, flush_cnt} !== 96'd0) begin
      n_fail++; $display("FAIL reset_async_counters: got %0d/%0d/%0d expected 0/0/0",
                         retire_cnt, stall_cnt, flush_cnt);
    end
    n_checks++;
    if ({pc_en, idex_en} !== 2'b00) begin
      n_fail++; $display("FAIL reset_pc_en_stall: got %b expected 00", {pc_en, idex_en});
    end
    stall = 1'b0; #1;
    n_checks++;
    if ({pc_en, idex_en} !== 2'b11) begin
      n_fail++; $display("FAIL reset_pc_en_run: got %b expected 11", {pc_en, idex_en});
    end
    tick();
    #2 rst = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (retire_cnt !== 32'd0) begin
        n_fail++; $display("FAIL reset_release_retire%0d: got %0d expected 0", i, retire_cnt);
      end
    end
    drive_idle();
  endtask

  task automatic test_straight_line();
    do_reset();
    if_valid = 1; tick();
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd5; id_regwrite = 1; tick();
    n_checks++;
    if ({idex_valid, idex_rd, idex_rs1, idex_rs2, idex_regwrite} !== {1'b1, 5'd5, 5'd1, 5'd2, 1'b1}) begin
      n_fail++; $display("FAIL line_idex: got v%b rd%0d rs1 %0d rs2 %0d rw%b expected v1 rd5 rs1 1 rs2 2 rw1",
                         idex_valid, idex_rd, idex_rs1, idex_rs2, idex_regwrite);
    end
    id_rd = 5'd6; tick();
    id_rd = 5'd7; if_valid = 0; tick();
    n_checks++;
    if ({memwb_valid, memwb_rd, memwb_regwrite} !== {1'b1, 5'd5, 1'b1}) begin
      n_fail++; $display("FAIL line_memwb_rd: got v%b rd%0d expected v1 rd5", memwb_valid, memwb_rd);
    end
    n_checks++;
    if (retire_cnt !== 32'd0) begin
      n_fail++; $display("FAIL line_retire_early: got %0d expected 0", retire_cnt);
    end
    id_rd = 5'd0; id_regwrite = 0;
    tick(); tick(); tick();
    n_checks++;
    if (retire_cnt !== 32'd3) begin
      n_fail++; $display("FAIL line_retire: got %0d expected 3", retire_cnt);
    end
    drive_idle();
  endtask

  task automatic test_stall();
    do_reset();
    if_valid = 1; tick();
    id_rd = 5'd3; id_regwrite = 1; tick();
    stall = 1; #1;
    n_checks++;
    if ({pc_en, idex_en} !== 2'b00) begin
      n_fail++; $display("FAIL stall_enables: got %b expected 00", {pc_en, idex_en});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({ifid_valid, idex_valid, idex_rd, exmem_valid} !== {1'b1, 1'b1, 5'd3, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold%0d: got ifid%b idex%b rd%0d exmem%b expected 1 1 3 0",
                           i, ifid_valid, idex_valid, idex_rd, exmem_valid);
      end
    end
    n_checks++;
    if (stall_cnt !== 32'd2) begin
      n_fail++; $display("FAIL stall_cnt: got %0d expected 2", stall_cnt);
    end
    stall = 0; if_valid = 0; id_rd = 5'd4; tick();
    n_checks++;
    if ({exmem_valid, exmem_rd, idex_rd} !== {1'b1, 5'd3, 5'd4}) begin
      n_fail++; $display("FAIL stall_resume: got exmem v%b rd%0d idex rd%0d expected 1 3 4",
                         exmem_valid, exmem_rd, idex_rd);
    end
    id_rd = 0; tick();
    n_checks++;
    if (retire_cnt !== 32'd0) begin
      n_fail++; $display("FAIL stall_retire_delay: got %0d expected 0", retire_cnt);
    end
    tick();
    n_checks++;
    if (retire_cnt !== 32'd1) begin
      n_fail++; $display("FAIL stall_retire: got %0d expected 1", retire_cnt);
    end
    drive_idle();
  endtask

  task automatic test_flush();
    do_reset();
    if_valid = 1; tick();
    id_rd = 5'd9; tick();
    id_rd = 5'd10; id_regwrite = 1; flush = 1; tick();
    n_checks++;
    if ({ifid_valid, idex_valid, exmem_valid, exmem_rd} !== {1'b0, 1'b0, 1'b1, 5'd9}) begin
      n_fail++; $display("FAIL flush_stages: got ifid%b idex%b exmem v%b rd%0d expected 0 0 1 9",
                         ifid_valid, idex_valid, exmem_valid, exmem_rd);
    end
    n_checks++;
    if (flush_cnt !== 32'd1) begin
      n_fail++; $display("FAIL flush_cnt: got %0d expected 1", flush_cnt);
    end
    flush = 0; if_valid = 0; id_rd = 0; id_regwrite = 0;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (retire_cnt !== 32'd1) begin
      n_fail++; $display("FAIL flush_no_wrong_path: got %0d expected 1", retire_cnt);
    end
    drive_idle();
  endtask

  task automatic test_both_high();
    do_reset();
    if_valid = 1; tick();
    id_rd = 5'd12; tick();
    stall = 1; flush = 1; id_rd = 5'd13; #1;
    n_checks++;
    if (pc_en !== 1'b0) begin
      n_fail++; $display("FAIL both_pc_en: got %b expected 0", pc_en);
    end
    tick();
    n_checks++;
    if ({ifid_valid, idex_valid, idex_rd, exmem_valid} !== {1'b1, 1'b1, 5'd12, 1'b0}) begin
      n_fail++; $display("FAIL both_stall_behaviour: got ifid%b idex%b rd%0d exmem%b expected 1 1 12 0",
                         ifid_valid, idex_valid, idex_rd, exmem_valid);
    end
    n_checks++;
    if ({flush_cnt, stall_cnt} !== {32'd0, 32'd1}) begin
      n_fail++; $display("FAIL both_counters: got flush %0d stall %0d expected 0 1", flush_cnt, stall_cnt);
    end
    stall = 0; tick();
    n_checks++;
    if ({flush_cnt, exmem_rd, idex_valid} !== {32'd1, 5'd12, 1'b0}) begin
      n_fail++; $display("FAIL both_reflush: got flush %0d exmem rd%0d idex%b expected 1 12 0",
                         flush_cnt, exmem_rd, idex_valid);
    end
    drive_idle();
  endtask

  task automatic test_wrap();
    do_reset();
    if_valid = 1; id_rd = 5'd1;
    for (int i = 0; i < 17; i++) tick();
    if_valid = 0;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (w_retire_cnt !== 4'd1) begin
      n_fail++; $display("FAIL wrap_retire4: got %0d expected 1", w_retire_cnt);
    end
    n_checks++;
    if (retire_cnt !== 32'd17) begin
      n_fail++; $display("FAIL wrap_retire32: got %0d expected 17", retire_cnt);
    end
    drive_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom);
      id_rs2      = 5'($urandom);
      id_rd       = 5'($urandom);
      id_regwrite = 1'($urandom);
      id_memread  = 1'($urandom);
      stall       = ($urandom_range(0, 4) == 0);
      flush       = ($urandom_range(0, 6) == 0);
      #1;
      n_checks++;
      if ({pc_en, idex_en} !== {2{!stall}}) begin
        n_fail++; $display("FAIL rand_enables c%0d: got %b expected %b", c, {pc_en, idex_en}, {2{!stall}});
      end
      tick();
      n_checks++;
      if ({ifid_valid, idex_valid, idex_rs1, idex_rs2, idex_rd, idex_regwrite} !==
          {pipe[0].v, pipe[1].v, pipe[1].rs1, pipe[1].rs2, pipe[1].rd, pipe[1].rw}) begin
        n_fail++; $display("FAIL rand_front c%0d: got %0h expected %0h", c,
          {ifid_valid, idex_valid, idex_rs1, idex_rs2, idex_rd, idex_regwrite},
          {pipe[0].v, pipe[1].v, pipe[1].rs1, pipe[1].rs2, pipe[1].rd, pipe[1].rw});
      end
      n_checks++;
      if ({exmem_valid, exmem_rd, exmem_regwrite, exmem_memread, memwb_valid, memwb_rd, memwb_regwrite} !==
          {pipe[2].v, pipe[2].rd, pipe[2].rw, pipe[2].mr, pipe[3].v, pipe[3].rd, pipe[3].rw}) begin
        n_fail++; $display("FAIL rand_back c%0d: got %0h expected %0h", c,
          {exmem_valid, exmem_rd, exmem_regwrite, exmem_memread, memwb_valid, memwb_rd, memwb_regwrite},
          {pipe[2].v, pipe[2].rd, pipe[2].rw, pipe[2].mr, pipe[3].v, pipe[3].rd, pipe[3].rw});
      end
      n_checks++;
      if ({retire_cnt, stall_cnt, flush_cnt} !== {m_retire, m_stall, m_flush}) begin
        n_fail++; $display("FAIL rand_counters c%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", c,
                           retire_cnt, stall_cnt, flush_cnt, m_retire, m_stall, m_flush);
      end
      n_checks++;
      if ({w_retire_cnt, w_stall_cnt, w_flush_cnt} !== {m_retire[3:0], m_stall[3:0], m_flush[3:0]}) begin
        n_fail++; $display("FAIL rand_counters4 c%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", c,
                           w_retire_cnt, w_stall_cnt, w_flush_cnt, m_retire[3:0], m_stall[3:0], m_flush[3:0]);
      end
      n_checks++;
      if ({w_pc_en, w_idex_en, w_ifid_valid, w_idex_valid, w_idex_rs1, w_idex_rs2, w_idex_rd,
           w_idex_regwrite, w_exmem_valid, w_exmem_rd, w_exmem_regwrite, w_exmem_memread,
           w_memwb_valid, w_memwb_rd, w_memwb_regwrite} !==
          {{2{!stall}}, pipe[0].v, pipe[1].v, pipe[1].rs1, pipe[1].rs2, pipe[1].rd, pipe[1].rw,
           pipe[2].v, pipe[2].rd, pipe[2].rw, pipe[2].mr, pipe[3].v, pipe[3].rd, pipe[3].rw}) begin
        n_fail++; $display("FAIL rand_tags4 c%0d: narrow-counter instance tags differ from model", c);
      end
    end
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_clear();
    test_reset();
    test_straight_line();
    test_stall();
    test_flush();
    test_both_high();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
